// File: rtl/vga_timing_pkg.sv
// Raster constants for 640x480@60, sync polarity encodings and the shared
// coordinate type used by the VGA sync generator.
package vga_timing_pkg;

  typedef logic [10:0] coord_t;

  localparam int H_ACTIVE_640 = 640;
  localparam int H_FP_640     = 16;
  localparam int H_SYNC_640   = 96;
  localparam int H_BP_640     = 48;

  localparam int V_ACTIVE_480 = 480;
  localparam int V_FP_480     = 10;
  localparam int V_SYNC_480   = 2;
  localparam int V_BP_480     = 33;

  localparam int SYNC_ACTIVE_LOW  = 0;
  localparam int SYNC_ACTIVE_HIGH = 1;

  // Length of one axis (pixels per line or lines per frame).
  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int h_total(input int active, input int fp,
                                 input int sync, input int bp);
    return axis_total(active, fp, sync, bp);
  endfunction

  function automatic int v_total(input int active, input int fp,
                                 input int sync, input int bp);
    return axis_total(active, fp, sync, bp);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus decode of the sync and
// visible windows. The decodes look at the value being loaded this edge so
// the parent can register them in lockstep with the count.
import vga_timing_pkg::*;

module vga_axis_counter #(
  parameter int ACTIVE = H_ACTIVE_640,
  parameter int FP     = H_FP_640,
  parameter int SYNC   = H_SYNC_640,
  parameter int BP     = H_BP_640
) (
  input  logic        i_clk,
  input  logic        i_clear,
  input  logic        i_en,
  output logic [10:0] o_count,
  output logic        o_wrap,
  output logic        o_sync_active,
  output logic        o_in_active
);

  localparam int     TOTAL   = axis_total(ACTIVE, FP, SYNC, BP);
  localparam coord_t LAST    = coord_t'(TOTAL - 1);
  localparam coord_t SYNC_LO = coord_t'(ACTIVE + FP);
  localparam coord_t SYNC_HI = coord_t'(ACTIVE + FP + SYNC);
  localparam coord_t ACT_END = coord_t'(ACTIVE);

  coord_t r_count;
  coord_t w_count_step;
  coord_t w_count_nxt;

  always_comb begin
    w_count_step = r_count;
    if (i_en) begin
      if (r_count == LAST) w_count_step = '0;
      else                 w_count_step = r_count + coord_t'(1);
    end
  end

  assign w_count_nxt = i_clear ? '0 : w_count_step;

  always_ff @(posedge i_clk) begin
    if (i_clear) r_count <= '0;
    else         r_count <= w_count_step;
  end

  assign o_count       = r_count;
  assign o_wrap        = (r_count == LAST);
  assign o_sync_active = (w_count_nxt >= SYNC_LO) && (w_count_nxt < SYNC_HI);
  assign o_in_active   = (w_count_nxt < ACT_END);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel-rate divider, h/v position counters and
// registered sync/active decode. Define VGA_SYNC_FRAME_COUNT_EN to add frame_cnt/frame_start.
import vga_timing_pkg::*;

module vga_sync_gen #(
  parameter int PCLK_DIV = 1,
  parameter int H_ACTIVE = H_ACTIVE_640,
  parameter int H_FP     = H_FP_640,
  parameter int H_SYNC   = H_SYNC_640,
  parameter int H_BP     = H_BP_640,
  parameter int V_ACTIVE = V_ACTIVE_480,
  parameter int V_FP     = V_FP_480,
  parameter int V_SYNC   = V_SYNC_480,
  parameter int V_BP     = V_BP_480,
  parameter int SYNC_POL = SYNC_ACTIVE_LOW
) (
  input  logic        clk,
  input  logic        reset,
  output logic        hsync,
  output logic        vsync,
  output logic [10:0] x_px,
  output logic [10:0] y_px,
  output logic        activevideo,
`ifdef VGA_SYNC_FRAME_COUNT_EN
  output logic [15:0] frame_cnt,
  output logic        frame_start,
`endif
  output logic        px_clk
);

  localparam logic SYNC_ON  = (SYNC_POL == SYNC_ACTIVE_HIGH);
  localparam logic SYNC_OFF = ~SYNC_ON;

  logic w_tick;

  generate
    if (PCLK_DIV == 1) begin : g_div1
      // First edge after reset only shows (0,0) as active; counting starts on the next.
      logic r_armed;

      always_ff @(posedge clk) begin
        if (reset) r_armed <= 1'b0;
        else       r_armed <= 1'b1;
      end

      assign w_tick = r_armed;
      assign px_clk = clk;
    end else begin : g_divn
      localparam int               DIV_W    = $clog2(PCLK_DIV);
      localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PCLK_DIV - 1);
      localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(PCLK_DIV / 2);

      logic [DIV_W-1:0] r_div;
      logic [DIV_W-1:0] w_div_nxt;
      logic             r_px_clk;

      assign w_div_nxt = (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);

      // px_clk is high for the first half of each divider period.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_div    <= '0;
          r_px_clk <= 1'b1;
        end else begin
          r_div    <= w_div_nxt;
          r_px_clk <= (w_div_nxt < DIV_HALF);
        end
      end

      assign w_tick = (r_div == DIV_LAST);
      assign px_clk = r_px_clk;
    end
  endgenerate

  coord_t w_h_count;
  coord_t w_v_count;
  logic   w_h_wrap;
  logic   w_v_wrap;
  logic   w_h_sync;
  logic   w_v_sync;
  logic   w_h_in;
  logic   w_v_in;
  logic   w_v_en;

  assign w_v_en = w_tick & w_h_wrap;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .i_clk         (clk),
    .i_clear       (reset),
    .i_en          (w_tick),
    .o_count       (w_h_count),
    .o_wrap        (w_h_wrap),
    .o_sync_active (w_h_sync),
    .o_in_active   (w_h_in)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .i_clk         (clk),
    .i_clear       (reset),
    .i_en          (w_v_en),
    .o_count       (w_v_count),
    .o_wrap        (w_v_wrap),
    .o_sync_active (w_v_sync),
    .o_in_active   (w_v_in)
  );

  logic r_hsync;
  logic r_vsync;
  logic r_active;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hsync  <= SYNC_OFF;
      r_vsync  <= SYNC_OFF;
      r_active <= 1'b0;
    end else begin
      r_hsync  <= w_h_sync ? SYNC_ON : SYNC_OFF;
      r_vsync  <= w_v_sync ? SYNC_ON : SYNC_OFF;
      r_active <= w_h_in & w_v_in;
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign activevideo = r_active;
  assign x_px        = w_h_count;
  assign y_px        = w_v_count;

`ifdef VGA_SYNC_FRAME_COUNT_EN
  logic        w_frame_wrap;
  logic [15:0] r_frame_cnt;
  logic        r_frame_start;

  assign w_frame_wrap = w_tick & w_h_wrap & w_v_wrap;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_cnt   <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_frame_wrap;
      if (w_frame_wrap) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt   = r_frame_cnt;
  assign frame_start = r_frame_start;
`else
  logic w_v_wrap_unused;
  assign w_v_wrap_unused = w_v_wrap;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three instances (full 640x480 at div 1, small rasters
// at div 2 / div 4) checked every cycle against an arithmetic raster model.
module tb_vga_sync_gen;

  typedef struct {
    int div;
    int ha, hfp, hs, hbp;
    int va, vfp, vs, vbp;
    bit pol;
  } cfg_t;

  typedef struct packed {
    logic        hs, vs, av, pxc, fs;
    logic [10:0] x, y;
    logic [15:0] fc;
  } obs_t;

  localparam int S_HA = 16, S_HFP = 2, S_HS = 4, S_HBP = 3;
  localparam int S_VA = 10, S_VFP = 1, S_VS = 2, S_VBP = 2;

  logic clk = 1'b0;
  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;

  logic hsync_a, vsync_a, av_a, pxc_a;
  logic hsync_b, vsync_b, av_b, pxc_b;
  logic hsync_c, vsync_c, av_c, pxc_c;
  logic [10:0] x_a, y_a, x_b, y_b, x_c, y_c;
  logic [15:0] fc_a, fc_b, fc_c;
  logic fs_a, fs_b, fs_c;

  always #5 clk = ~clk;

  vga_sync_gen u_dut_a (
    .clk(clk), .reset(rst_a), .hsync(hsync_a), .vsync(vsync_a),
    .x_px(x_a), .y_px(y_a), .activevideo(av_a),
`ifdef VGA_SYNC_FRAME_COUNT_EN
    .frame_cnt(fc_a), .frame_start(fs_a),
`endif
    .px_clk(pxc_a)
  );

  vga_sync_gen #(
    .PCLK_DIV(2), .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP), .SYNC_POL(1)
  ) u_dut_b (
    .clk(clk), .reset(rst_b), .hsync(hsync_b), .vsync(vsync_b),
    .x_px(x_b), .y_px(y_b), .activevideo(av_b),
`ifdef VGA_SYNC_FRAME_COUNT_EN
    .frame_cnt(fc_b), .frame_start(fs_b),
`endif
    .px_clk(pxc_b)
  );

  vga_sync_gen #(
    .PCLK_DIV(4), .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP), .SYNC_POL(0)
  ) u_dut_c (
    .clk(clk), .reset(rst_c), .hsync(hsync_c), .vsync(vsync_c),
    .x_px(x_c), .y_px(y_c), .activevideo(av_c),
`ifdef VGA_SYNC_FRAME_COUNT_EN
    .frame_cnt(fc_c), .frame_start(fs_c),
`endif
    .px_clk(pxc_c)
  );

`ifndef VGA_SYNC_FRAME_COUNT_EN
  assign fc_a = '0; assign fc_b = '0; assign fc_c = '0;
  assign fs_a = 1'b0; assign fs_b = 1'b0; assign fs_c = 1'b0;
`endif

  // Clock edges seen with reset low since the last reset edge.
  int k_a = 0, k_b = 0, k_c = 0;
  always @(posedge clk) begin
    k_a <= rst_a ? 0 : k_a + 1;
    k_b <= rst_b ? 0 : k_b + 1;
    k_c <= rst_c ? 0 : k_c + 1;
  end

  int n_vec = 0;
  int n_err = 0;
  cfg_t cfg_a, cfg_b, cfg_c;
  bit counting = 1'b0;
  int cnt_av_a = 0, cnt_hs_a = 0, cnt_vs_b = 0, cnt_fs_c = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Raster position follows from the number of pixel ticks since reset.
  function automatic obs_t model(input cfg_t c, input int k);
    obs_t e;
    int ht, vt, ticks, xi, yi, hs_lo, vs_lo;
    bit tick_edge;
    ht = c.ha + c.hfp + c.hs + c.hbp;
    vt = c.va + c.vfp + c.vs + c.vbp;
    e = '0;
    if (k == 0) begin
      e.hs  = ~c.pol;
      e.vs  = ~c.pol;
      e.pxc = (c.div == 1) ? 1'b0 : 1'b1;
      return e;
    end
    ticks = (c.div == 1) ? k - 1 : k / c.div;
    xi = ticks % ht;
    yi = (ticks / ht) % vt;
    hs_lo = c.ha + c.hfp;
    vs_lo = c.va + c.vfp;
    e.x   = 11'(xi);
    e.y   = 11'(yi);
    e.av  = (xi < c.ha) && (yi < c.va);
    e.hs  = (xi >= hs_lo && xi < hs_lo + c.hs) ? c.pol : ~c.pol;
    e.vs  = (yi >= vs_lo && yi < vs_lo + c.vs) ? c.pol : ~c.pol;
    e.pxc = (c.div == 1) ? 1'b0 : ((k % c.div) < (c.div / 2));
    tick_edge = (c.div == 1) ? (k >= 2) : ((k % c.div) == 0);
    e.fs  = tick_edge && ((ticks % (ht * vt)) == 0);
    e.fc  = 16'(ticks / (ht * vt));
    return e;
  endfunction

  task automatic check_dut(input string n, input cfg_t c, input int k, input obs_t o);
    obs_t e;
    e = model(c, k);
    check_val({n, ".x_px"}, int'(o.x), int'(e.x));
    check_val({n, ".y_px"}, int'(o.y), int'(e.y));
    check_val({n, ".activevideo"}, int'(o.av), int'(e.av));
    check_val({n, ".hsync"}, int'(o.hs), int'(e.hs));
    check_val({n, ".vsync"}, int'(o.vs), int'(e.vs));
    check_val({n, ".px_clk"}, int'(o.pxc), int'(e.pxc));
`ifdef VGA_SYNC_FRAME_COUNT_EN
    check_val({n, ".frame_start"}, int'(o.fs), int'(e.fs));
    check_val({n, ".frame_cnt"}, int'(o.fc), int'(e.fc));
`endif
  endtask

  function automatic obs_t pack_obs(input logic hs, input logic vs, input logic av,
                                    input logic pxc, input logic fs, input logic [10:0] x,
                                    input logic [10:0] y, input logic [15:0] fc);
    obs_t o;
    o.hs = hs; o.vs = vs; o.av = av; o.pxc = pxc; o.fs = fs;
    o.x = x; o.y = y; o.fc = fc;
    return o;
  endfunction

  task automatic cycle();
    @(negedge clk);
    check_dut("a", cfg_a, k_a, pack_obs(hsync_a, vsync_a, av_a, pxc_a, fs_a, x_a, y_a, fc_a));
    check_dut("b", cfg_b, k_b, pack_obs(hsync_b, vsync_b, av_b, pxc_b, fs_b, x_b, y_b, fc_b));
    check_dut("c", cfg_c, k_c, pack_obs(hsync_c, vsync_c, av_c, pxc_c, fs_c, x_c, y_c, fc_c));
    if (counting) begin
      if (k_a >= 1 && k_a <= 800) begin
        if (av_a) cnt_av_a++;
        if (!hsync_a) cnt_hs_a++;
      end
      if (k_b >= 1 && k_b <= 750 && vsync_b) cnt_vs_b++;
      if (fs_c) cnt_fs_c++;
    end
  endtask

  initial begin
    obs_t e;
    bit found;
    int rem_a, rem_b, rem_c;
    cfg_a = '{1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
    cfg_b = '{2, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, 1'b1};
    cfg_c = '{4, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, 1'b0};

    repeat (3) cycle();
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    // Free run: one full default line, and three small frames on the div-4 instance.
    counting = 1'b1;
    repeat (4510) cycle();
    counting = 1'b0;
    check_val("a.line_active_ticks", cnt_av_a, 640);
    check_val("a.line_hsync_ticks", cnt_hs_a, 96);
    check_val("b.frame_vsync_clks", cnt_vs_b, 2 * 25 * 2);
`ifdef VGA_SYNC_FRAME_COUNT_EN
    check_val("c.frame_start_pulses", cnt_fs_c, 3);
    check_val("c.frame_cnt_after_3", int'(fc_c), 3);
`endif

    // Mid-frame abort on the div-2 instance at (20,8).
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      e = model(cfg_b, k_b);
      if (e.x == 11'd20 && e.y == 11'd8) begin
        rst_b = 1'b1;
        cycle();
        rst_b = 1'b0;
        found = 1'b1;
        check_val("b.midframe_x", int'(x_b), 0);
        check_val("b.midframe_y", int'(y_b), 0);
        check_val("b.midframe_av", int'(av_b), 0);
      end else begin
        cycle();
      end
    end
    check_val("b.midframe_reached", int'(found), 1);

    // Random reset pulses on all instances.
    rem_a = 0; rem_b = 0; rem_c = 0;
    for (int i = 0; i < 6000; i++) begin
      if (rem_a == 0 && $urandom_range(0, 799) == 0) rem_a = $urandom_range(1, 4);
      if (rem_b == 0 && $urandom_range(0, 399) == 0) rem_b = $urandom_range(1, 4);
      if (rem_c == 0 && $urandom_range(0, 399) == 0) rem_c = $urandom_range(1, 4);
      rst_a = (rem_a > 0); rst_b = (rem_b > 0); rst_c = (rem_c > 0);
      if (rem_a > 0) rem_a--;
      if (rem_b > 0) rem_b--;
      if (rem_c > 0) rem_c--;
      cycle();
    end
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    repeat (20) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
VGA raster timing generator for 640x480@60 Hz (800x525 total).
- Produces hsync, vsync, an active-video flag, current pixel coordinates and a pixel clock derived from the system clock.
- Sits between the board clock and pixel-generation logic; downstream logic samples x_px/y_px/activevideo on px_clk.

Parameters:
- PCLK_DIV, 1, system clocks per pixel; allowed values are 1 or an even number ≥2.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch, in pixels.
- H_SYNC, 96, hsync pulse width, in pixels.
- H_BP, 48, horizontal back porch, in pixels.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch, in lines.
- V_SYNC, 2, vsync pulse width, in lines.
- V_BP, 33, vertical back porch, in lines.
- SYNC_POL, 0, sync active level; 0 means active-low.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- x_px  out  11  horizontal counter, 0..H_TOTAL-1
- y_px  out  11  vertical counter, 0..V_TOTAL-1
- activevideo  out  1  high while x_px<H_ACTIVE and y_px<V_ACTIVE
- px_clk  out  1  pixel clock

Behaviour:
- Derived constants: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Pixel tick (internal enable):
  - PCLK_DIV=1: tick every clk cycle; px_clk = clk (combinational passthrough).
  - Otherwise: a divider counter 0..PCLK_DIV-1 produces tick when it equals PCLK_DIV-1.
  - px_clk is registered: high for divider values 0..PCLK_DIV/2-1, low otherwise (50% duty). Outputs therefore change just before px_clk rises.
- Counter advance on each tick:
  - x_px increments.
  - At H_TOTAL-1, x_px wraps to 0 and y_px increments.
  - At (H_TOTAL-1, V_TOTAL-1), both wrap to 0.
- Decoding (all outputs registered, updated in the same clk edge as the counters; no extra latency relative to x_px/y_px):
  - hsync is active when H_ACTIVE+H_FP ≤ x_px < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync is active when V_ACTIVE+V_FP ≤ y_px < V_ACTIVE+V_FP+V_SYNC (490..491).
  - Active level is SYNC_POL; inactive level is ~SYNC_POL.
  - activevideo is decoded as in Ports.
- Reset (sampled on clk; overrides tick):
  - Divider=0, x_px=0, y_px=0, px_clk=1 (when PCLK_DIV>1).
  - hsync=vsync=inactive level, activevideo=0.
  - Reset held mid-frame aborts the frame.
  - First cycle after release: activevideo=1 at (0,0); first tick moves to (1,0).
- Counters are 11 bits wide; parameter sets with totals >2047 are illegal.
- Values never exceed TOTAL-1; no other states exist.

Optional Feature:
Macro VGA_SYNC_FRAME_COUNT_EN.
- Defined: adds outputs frame_cnt [15:0] and frame_start [0:0].
  - frame_cnt resets to 0 and increments (mod 2^16) on the tick that wraps to (0,0).
  - frame_start is a one-clk pulse coincident with that wrap.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package vga_timing_pkg holds:
  - 640x480 timing constants and the derived H_TOTAL/V_TOTAL functions.
  - The sync polarity localparams.
  - The typedef coord_t (logic [10:0]).
- One natural sub-module: vga_axis_counter.
  - Parameterised ACTIVE/FP/SYNC/BP.
  - Inputs: en and clear. Outputs: count, wrap, sync_active, in_active.
  - Instantiated twice: horizontal with en=tick; vertical with en=tick & h_wrap.

Test Plan:
- Reset, PCLK_DIV=1: assert reset 3 clks -> x_px=0, y_px=0, hsync=vsync=1, activevideo=0. Release -> activevideo=1; next clk x_px=1.
- Line timing: run one line -> activevideo high for exactly 640 ticks. hsync low for exactly 96 ticks starting at x_px=656. Wrap 799->0 with y_px incrementing.
- Frame timing: run 800*525 ticks -> vsync low for exactly 2 lines (y_px 490,491), i.e. 1600 ticks. Return to (0,0) after 420000 ticks.
- Divider, PCLK_DIV=2: px_clk toggles every clk (period 2 clk). x_px advances once per 2 clks. Full frame takes 840000 clks.
- Mid-frame reset: at (700,300) assert reset 1 clk -> next state (0,0), syncs inactive, activevideo=0. Resume counting from 0.
- VGA_SYNC_FRAME_COUNT_EN: run 3 frames -> frame_start pulses 3 times, each at the wrap to (0,0). frame_cnt reads 3.
